// File: rtl/adder_pkg.sv
// Shared definitions for the multicycle adder: FSM encodings, default
// geometry and the slice-counter width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    // Slice counter never collapses to zero bits, even with a single slice.
    function automatic int ctr_width(input int num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple adder for one slice; also exposes the carry into the
// top bit so the caller can derive signed overflow.
module chunk_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [N:0] carry;

    assign carry[0] = ci;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign s[gi]        = x[gi] ^ y[gi] ^ carry[gi];
            assign carry[gi+1]  = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co       = carry[N];
    assign c_msb_in = carry[N-1];

endmodule

// File: rtl/multicycle_adder.sv
// Adds or subtracts two WIDTH-bit operands CHUNK bits per cycle, then holds
// the result and flags until the consumer takes them.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int                NUM_SLICES = WIDTH / CHUNK;
    localparam int                KW         = ctr_width(NUM_SLICES);
    localparam logic [KW-1:0]     LAST_K     = KW'(NUM_SLICES - 1);
    localparam logic [WIDTH-1:0]  SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

    state_t            state_reg;
    state_t            state_next;
    logic [KW-1:0]     k_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              cout_reg;
    logic              overflow_reg;
    logic              zero_reg;

    logic              accept;
    logic              run_step;
    logic              last_slice;
    logic [31:0]       shamt;
    logic [CHUNK-1:0]  x_slice;
    logic [CHUNK-1:0]  y_slice;
    logic [CHUNK-1:0]  s_slice;
    logic              slice_co;
    logic              slice_c_msb;
    logic [WIDTH-1:0]  sum_merged;

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign accept     = in_ready && start;
    assign run_step   = (state_reg == RUN);
    assign last_slice = (k_reg == LAST_K);

    // Current slice is brought down to bit 0 by shifting, which keeps the
    // selection width-clean for every legal CHUNK.
    assign shamt   = 32'(k_reg) * 32'(CHUNK);
    assign x_slice = CHUNK'(a_reg >> shamt);
    assign y_slice = CHUNK'(b_reg >> shamt);

    chunk_adder #(
        .N (CHUNK)
    ) u_chunk_adder (
        .x        (x_slice),
        .y        (y_slice),
        .ci       (carry_reg),
        .s        (s_slice),
        .co       (slice_co),
        .c_msb_in (slice_c_msb)
    );

    assign sum_merged = (sum_reg & ~(SLICE_MASK << shamt)) | (WIDTH'(s_slice) << shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            // A start arriving with the handshake is not seen: in_ready is low.
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg        <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            carry_reg    <= 1'b0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1, so cout=1 means no borrow.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            k_reg     <= '0;
        end else if (run_step) begin
            sum_reg   <= sum_merged;
            carry_reg <= slice_co;
            k_reg     <= last_slice ? '0 : k_reg + KW'(1);
            if (last_slice) begin
                cout_reg     <= slice_co;
                overflow_reg <= slice_co ^ slice_c_msb;
                zero_reg     <= ~|sum_merged;
            end
        end
    end

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;
    assign zero     = zero_reg;

endmodule
